// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// fixed latencies and FSM state type.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage : mult_div_unit_pkg

// File: rtl/mult_div_unit_if.sv
// Execute-stage bundle between the pipeline (master) and the multiply/divide
// unit (slave): launch/MTHI/MTLO controls, operands, HI/LO and the MFHI/MFLO read port.
interface mult_div_unit_if;

    logic        Start_E;
    logic [1:0]  MDControl_E;
    logic        MDWrite_E;
    logic        HiLo_E;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic        Busy_E;
    logic [31:0] HI_E;
    logic [31:0] LO_E;
    logic [31:0] MDOut_E;

    modport master (
        output Start_E, MDControl_E, MDWrite_E, HiLo_E, RD1_E, RD2_E,
        input  Busy_E, HI_E, LO_E, MDOut_E
    );

    modport slave (
        input  Start_E, MDControl_E, MDWrite_E, HiLo_E, RD1_E, RD2_E,
        output Busy_E, HI_E, LO_E, MDOut_E
    );

endinterface : mult_div_unit_if

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Arithmetic is combinational on latched operands and committed on the last busy cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    md_op_t             op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;

    logic [63:0]        prod_s, prod_u;
    logic               div_zero;
    logic [31:0]        a_mag, b_mag, b_den_s, b_den_u;
    logic [31:0]        q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division works on magnitudes; 0x80000000 has magnitude 2^31 as unsigned,
    // so the overflow case 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign div_zero = (b_q == 32'd0);
    assign a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign b_den_s  = div_zero ? 32'd1 : b_mag;
    assign b_den_u  = div_zero ? 32'd1 : b_q;
    assign q_mag    = a_mag / b_den_s;
    assign r_mag    = a_mag % b_den_s;
    assign quot_s   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    assign quot_u   = a_q / b_den_u;
    assign rem_u    = a_q % b_den_u;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;

        case (state_q)
            ST_IDLE: begin
                if (md.Start_E) begin
                    op_d    = md_op_t'(md.MDControl_E);
                    a_d     = md.RD1_E;
                    b_d     = md.RD2_E;
                    cnt_d   = md.MDControl_E[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end else if (md.MDWrite_E) begin
                    if (md.HiLo_E) hi_d = md.RD1_E;
                    else           lo_d = md.RD1_E;
                end
            end
            ST_BUSY: begin
                // Launch/write requests are ignored here; the hazard unit holds them off.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    case (op_q)
                        MD_MULT:  {hi_d, lo_d} = prod_s;
                        MD_MULTU: {hi_d, lo_d} = prod_u;
                        MD_DIV: begin
                            if (!div_zero) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        MD_DIVU: begin
                            if (!div_zero) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign md.Busy_E  = busy_q;
    assign md.HI_E    = hi_q;
    assign md.LO_E    = lo_q;
    assign md.MDOut_E = md.HiLo_E ? hi_q : lo_q;

endmodule : mult_div_unit

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have input clk (1 bit): sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have input reset (1 bit): asynchronous, active-low; state is cleared while reset=0.
REQ-003 The block SHALL have input Start_E (1 bit): pulse that launches the operation selected by MDControl_E.
REQ-004 The block SHALL have input MDControl_E (2 bits): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have input MDWrite_E (1 bit): MTHI/MTLO write strobe.
REQ-006 The block SHALL have input HiLo_E (1 bit): 1 selects HI, 0 selects LO, for both MDWrite_E and MDOut_E.
REQ-007 The block SHALL have input RD1_E (32 bits): rs operand; dividend/multiplicand; MTHI/MTLO data.
REQ-008 The block SHALL have input RD2_E (32 bits): rt operand; divisor/multiplier.
REQ-009 The block SHALL have output Busy_E (1 bit, registered): operation in flight.
REQ-010 The block SHALL have outputs HI_E and LO_E (32 bits each, registered): architectural HI and LO.
REQ-011 The block SHALL have output MDOut_E (32 bits, combinational): HI_E when HiLo_E=1, else LO_E (MFHI/MFLO).

Function
REQ-012 The block SHALL implement two states: IDLE and BUSY.
REQ-013 In IDLE with Start_E=1, the block SHALL, on that edge, latch operands and op, load counter with N (MULT/MULTU N=5, DIV/DIVU N=10), and enter BUSY with Busy_E=1.
REQ-014 In BUSY, the counter SHALL decrement each edge; on the edge where counter=1, it SHALL commit the result to HI_E/LO_E, clear Busy_E and return to IDLE, so Busy_E is high for exactly N cycles.
REQ-015 MULT/MULTU SHALL produce the signed/unsigned 64-bit product, with HI_E=[63:32] and LO_E=[31:0].
REQ-016 DIV/DIVU SHALL produce LO_E=quotient and HI_E=remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-017 A divisor of 0 SHALL still occupy N cycles and leave HI_E/LO_E unchanged.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO_E=0x80000000 and HI_E=0x00000000.
REQ-019 In IDLE with MDWrite_E=1 and Start_E=0, the block SHALL write RD1_E to HI_E (HiLo_E=1) or LO_E (HiLo_E=0) on that edge; Busy_E stays 0.
REQ-020 When Start_E and MDWrite_E are both 1 in IDLE, Start_E SHALL win and MDWrite_E is ignored.
REQ-021 In BUSY, Start_E and MDWrite_E SHALL be ignored, since the hazard unit stalls on Start_E|Busy_E.
REQ-022 Operand changes on RD1_E/RD2_E during BUSY SHALL NOT affect the result.

Reset
REQ-023 While reset=0, the block SHALL force state=IDLE, counter=0, Busy_E=0, HI_E=0, LO_E=0 and clear latched operands, immediately and independent of clk.
REQ-024 Reset asserted during BUSY SHALL abort the operation with no HI/LO commit; the first edge after release is a normal IDLE cycle.

Structure
REQ-025 A shared package SHALL hold the MDControl encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), MULT_LAT=5, DIV_LAT=10 and the state encoding.
REQ-026 The block SHALL be a single module with no sub-modules; arithmetic SHALL be combinational on the latched operands and committed on the final cycle.

Verification
REQ-027 MULT 0xFFFFFFFF x 0x00000002 SHALL give Busy_E high for 5 cycles, then HI_E=0xFFFFFFFF and LO_E=0xFFFFFFFE; MULTU on the same operands SHALL give HI_E=0x00000001 and LO_E=0xFFFFFFFE.
REQ-028 DIV -7 / 2 SHALL give Busy_E high for 10 cycles, then LO_E=0xFFFFFFFD (-3) and HI_E=0xFFFFFFFF (-1); DIVU 7 / 2 SHALL give LO_E=3 and HI_E=1.
REQ-029 MTHI of 0x12345678 followed by DIVU x / 0 SHALL leave HI_E=0x12345678 after 10 Busy_E cycles; DIV 0x80000000 / -1 SHALL give LO_E=0x80000000 and HI_E=0.
REQ-030 MULTU launched, then a Start_E DIVU and an MDWrite_E at cycle 2 of BUSY, SHALL complete only the MULTU, with HI/LO untouched by the ignored ops and Busy_E still 5 cycles.
REQ-031 reset=0 at cycle 3 of a DIV (HI/LO preloaded) SHALL drive Busy_E, HI_E and LO_E to 0 asynchronously with no later commit; a simultaneous Start_E and MDWrite_E in IDLE SHALL start the operation only.
